// File: rtl/div_arbiter_if.sv
// ---------------------------------------------------------------------------
// div_arbiter_if
//
// Purpose: bundles the requester-facing request channel and the shared
// response channel of the divider arbiter into one bus.
//
// Signals:
//   req_valid     [NREQ]        per-requester request valid
//   req_ready     [NREQ]        one-hot grant back to the requesters
//   req_dividend  [NREQ*WIDTH]  requester i at [i*WIDTH +: WIDTH]
//   req_divisor   [NREQ*WIDTH]  same packing as req_dividend
//   rsp_valid                   response valid
//   rsp_ready                   response accept
//   rsp_id        [IDW]         index of the served requester
//   rsp_quotient  [WIDTH]       quotient
//   rsp_remainder [WIDTH]       remainder
//   rsp_err                     divide-by-zero or timeout
//
// Modports:
//   slave  - arbiter view (consumes requests, produces responses)
//   master - requester/consumer view
// ---------------------------------------------------------------------------
interface div_arbiter_if #(
   parameter int NREQ  = 4,
   parameter int WIDTH = 8
);
   localparam int IDW = $clog2(NREQ);

   logic [NREQ-1:0]       req_valid;
   logic [NREQ-1:0]       req_ready;
   logic [NREQ*WIDTH-1:0] req_dividend;
   logic [NREQ*WIDTH-1:0] req_divisor;
   logic                  rsp_valid;
   logic                  rsp_ready;
   logic [IDW-1:0]        rsp_id;
   logic [WIDTH-1:0]      rsp_quotient;
   logic [WIDTH-1:0]      rsp_remainder;
   logic                  rsp_err;

   modport slave (
      input  req_valid, req_dividend, req_divisor, rsp_ready,
      output req_ready, rsp_valid, rsp_id, rsp_quotient, rsp_remainder, rsp_err
   );

   modport master (
      output req_valid, req_dividend, req_divisor, rsp_ready,
      input  req_ready, rsp_valid, rsp_id, rsp_quotient, rsp_remainder, rsp_err
   );
endinterface

// File: rtl/div_arbiter.sv
// ---------------------------------------------------------------------------
// div_arbiter
//
// Purpose: round-robin arbiter and sequencer that shares one iterative
// divider (start/done interface) among NREQ requesters. One request is in
// flight at a time: it is granted, issued to the divider, waited on, and the
// result is returned with the requester ID on a single response channel.
// Division by zero is answered locally (quotient all ones, remainder =
// dividend, err set) without touching the divider.
//
// Optional feature macro: DIV_TIMEOUT_EN
//   defined   - a watchdog aborts a divider operation after TIMEOUT WAIT
//               cycles without div_done, returning q=0, r=0, err=1 and
//               pulsing div_abort.
//   undefined - WAIT is unbounded and div_abort is tied low.
//
// Ports:
//   clk            rising-edge clock
//   rst_n          synchronous active-low reset
//   bus            div_arbiter_if.slave (request + response channels)
//   div_start      one-cycle pulse launching the divider
//   div_dividend   latched dividend, stable while the divider works
//   div_divisor    latched divisor, stable while the divider works
//   div_done       divider completion pulse
//   div_quotient   divider quotient, valid with div_done
//   div_remainder  divider remainder, valid with div_done
//   div_abort      one-cycle divider abort pulse (watchdog only)
// ---------------------------------------------------------------------------
module div_arbiter #(
   parameter int NREQ    = 4,
   parameter int WIDTH   = 8,
   parameter int TIMEOUT = 32
) (
   input  logic             clk,
   input  logic             rst_n,
   div_arbiter_if.slave     bus,
   output logic             div_start,
   output logic [WIDTH-1:0] div_dividend,
   output logic [WIDTH-1:0] div_divisor,
   input  logic             div_done,
   input  logic [WIDTH-1:0] div_quotient,
   input  logic [WIDTH-1:0] div_remainder,
   output logic             div_abort
);
   localparam int IDW = $clog2(NREQ);

   typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

   state_t           state;
   logic [IDW-1:0]   ptr;
   logic [IDW-1:0]   winner;
   logic             found;
   logic [NREQ-1:0]  grant;
   logic             handshake;
   logic [WIDTH-1:0] sel_dividend;
   logic [WIDTH-1:0] sel_divisor;

   logic             rsp_valid_q;
   logic [IDW-1:0]   rsp_id_q;
   logic [WIDTH-1:0] rsp_quotient_q;
   logic [WIDTH-1:0] rsp_remainder_q;
   logic             rsp_err_q;

`ifdef DIV_TIMEOUT_EN
   localparam int CNTW = $clog2(TIMEOUT + 1);
   logic [CNTW-1:0]  wait_cnt;
   logic             abort_q;
`endif

   // Round-robin winner search: scan upward from the requester after the
   // last one served, wrapping around, and take the first valid request.
   // The last-served requester is therefore checked last, which is what
   // gives every requester a fair turn.
   always_comb begin
      winner = '0;
      found  = 1'b0;
      for (int k = 1; k <= NREQ; k++) begin
         if (!found && bus.req_valid[(int'(ptr) + k) % NREQ]) begin
            winner = IDW'((int'(ptr) + k) % NREQ);
            found  = 1'b1;
         end
      end
   end

   // Grant and operand selection. The grant is only offered in IDLE and is
   // suppressed while reset is asserted so that no requester sees a
   // handshake that the reset would then throw away.
   always_comb begin
      grant        = '0;
      sel_dividend = '0;
      sel_divisor  = '0;
      for (int i = 0; i < NREQ; i++) begin
         if (winner == IDW'(i)) begin
            sel_dividend = bus.req_dividend[i*WIDTH +: WIDTH];
            sel_divisor  = bus.req_divisor[i*WIDTH +: WIDTH];
         end
      end
      if (found && (state == IDLE) && rst_n) begin
         grant[winner] = 1'b1;
      end
   end

   assign handshake     = |grant;
   assign bus.req_ready = grant;

   assign bus.rsp_valid     = rsp_valid_q;
   assign bus.rsp_id        = rsp_id_q;
   assign bus.rsp_quotient  = rsp_quotient_q;
   assign bus.rsp_remainder = rsp_remainder_q;
   assign bus.rsp_err       = rsp_err_q;

`ifdef DIV_TIMEOUT_EN
   assign div_abort = abort_q;
`else
   assign div_abort = 1'b0;
`endif

   // Sequencer FSM. All outputs are registered here; div_start and
   // div_abort default low every cycle so they can only ever be one-cycle
   // pulses. The response registers are loaded once (on the zero-divisor
   // shortcut, on div_done, or on watchdog expiry) and simply held while
   // the consumer applies backpressure in RESP.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state           <= IDLE;
         ptr             <= IDW'(NREQ - 1);
         rsp_valid_q     <= 1'b0;
         rsp_id_q        <= '0;
         rsp_quotient_q  <= '0;
         rsp_remainder_q <= '0;
         rsp_err_q       <= 1'b0;
         div_start       <= 1'b0;
         div_dividend    <= '0;
         div_divisor     <= '0;
`ifdef DIV_TIMEOUT_EN
         wait_cnt        <= '0;
         abort_q         <= 1'b0;
`endif
      end else begin
         div_start <= 1'b0;
`ifdef DIV_TIMEOUT_EN
         abort_q   <= 1'b0;
`endif
         case (state)
            IDLE: begin
               if (handshake) begin
                  ptr          <= winner;
                  rsp_id_q     <= winner;
                  div_dividend <= sel_dividend;
                  div_divisor  <= sel_divisor;
                  if (sel_divisor == '0) begin
                     rsp_quotient_q  <= '1;
                     rsp_remainder_q <= sel_dividend;
                     rsp_err_q       <= 1'b1;
                     rsp_valid_q     <= 1'b1;
                     state           <= RESP;
                  end else begin
                     div_start <= 1'b1;
                     state     <= ISSUE;
                  end
               end
            end

            ISSUE: begin
`ifdef DIV_TIMEOUT_EN
               wait_cnt <= '0;
`endif
               state <= WAIT;
            end

            WAIT: begin
               if (div_done) begin
                  rsp_quotient_q  <= div_quotient;
                  rsp_remainder_q <= div_remainder;
                  rsp_err_q       <= 1'b0;
                  rsp_valid_q     <= 1'b1;
                  state           <= RESP;
               end
`ifdef DIV_TIMEOUT_EN
               else if (wait_cnt == CNTW'(TIMEOUT - 1)) begin
                  rsp_quotient_q  <= '0;
                  rsp_remainder_q <= '0;
                  rsp_err_q       <= 1'b1;
                  rsp_valid_q     <= 1'b1;
                  abort_q         <= 1'b1;
                  state           <= RESP;
               end else begin
                  wait_cnt <= wait_cnt + 1'b1;
               end
`endif
            end

            RESP: begin
               if (bus.rsp_ready) begin
                  rsp_valid_q <= 1'b0;
                  state       <= IDLE;
               end
            end

            default: state <= IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_div_arbiter.sv
// ---------------------------------------------------------------------------
// tb_div_arbiter
//
// Purpose: directed self-checking bench for div_arbiter with NREQ=4,
// WIDTH=8, TIMEOUT=32. A small behavioural divider answers each div_start
// after a fixed latency of 8 cycles. Expected values are hand-computed
// constants. The watchdog sequence is compiled in only with DIV_TIMEOUT_EN.
// ---------------------------------------------------------------------------
module tb_div_arbiter;
   localparam int NREQ    = 4;
   localparam int WIDTH   = 8;
   localparam int TIMEOUT = 32;

   logic clk   = 1'b0;
   logic rst_n = 1'b0;

   div_arbiter_if #(.NREQ(NREQ), .WIDTH(WIDTH)) bus ();

   logic             div_start;
   logic [WIDTH-1:0] div_dividend;
   logic [WIDTH-1:0] div_divisor;
   logic             div_done;
   logic [WIDTH-1:0] div_quotient;
   logic [WIDTH-1:0] div_remainder;
   logic             div_abort;

   int n_checks = 0;
   int n_errs   = 0;
   int cyc      = 0;

   // Behavioural divider state: latency of model_delay cycles after the
   // div_start cycle; model_en lets the watchdog sequence silence it and
   // stray_done injects an unsolicited completion pulse.
   int               model_delay = 8;
   logic             model_busy  = 1'b0;
   int               model_rem   = 0;
   logic [WIDTH-1:0] model_a     = '0;
   logic [WIDTH-1:0] model_b     = '0;
   logic             model_en    = 1'b1;
   logic             stray_done  = 1'b0;

   div_arbiter #(.NREQ(NREQ), .WIDTH(WIDTH), .TIMEOUT(TIMEOUT)) dut (
      .clk           (clk),
      .rst_n         (rst_n),
      .bus           (bus),
      .div_start     (div_start),
      .div_dividend  (div_dividend),
      .div_divisor   (div_divisor),
      .div_done      (div_done),
      .div_quotient  (div_quotient),
      .div_remainder (div_remainder),
      .div_abort     (div_abort)
   );

   // Free-running clock, 10 time units per cycle.
   always #5 clk = ~clk;

   // Cycle counter used to measure grant-to-grant spacing.
   always @(posedge clk) cyc <= cyc + 1;

   // Divider model: capture operands on div_start, then count down so that
   // div_done is high exactly model_delay cycles after the start cycle.
   always @(posedge clk) begin
      if (div_start) begin
         model_busy <= 1'b1;
         model_rem  <= model_delay;
         model_a    <= div_dividend;
         model_b    <= div_divisor;
      end else if (model_busy) begin
         if (model_rem == 1) model_busy <= 1'b0;
         else                model_rem  <= model_rem - 1;
      end
   end

   assign div_done      = (model_busy && (model_rem == 1) && model_en) || stray_done;
   assign div_quotient  = (model_b == '0) ? '1 : model_a / model_b;
   assign div_remainder = (model_b == '0) ? model_a : model_a % model_b;

   // Load one requester's operands and raise its valid bit.
   task automatic applyStimulus(input int id, input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
      bus.req_dividend[id*WIDTH +: WIDTH] = a;
      bus.req_divisor[id*WIDTH +: WIDTH]  = b;
      bus.req_valid[id]                   = 1'b1;
   endtask

   // One comparison point: counts it, and on a miss counts the failure and
   // reports tag, observed and expected values.
   task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      n_checks++;
      assert (observed === expected) else begin
         n_errs++;
         $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
      end
   endtask

   // Directed sequence.
   initial begin
      int lat;
      int k;
      int last_grant;
      logic saw;
      int order[5]       = '{0, 1, 2, 3, 0};
      int q_tab[4]       = '{14, 22, 11, 15};
      int r_tab[4]       = '{2, 2, 0, 10};

      bus.req_valid    = '0;
      bus.req_dividend = '0;
      bus.req_divisor  = '0;
      bus.rsp_ready    = 1'b0;
      last_grant       = 0;

      $display("[TB] reset checks");
      applyStimulus(0, 8'd100, 8'd7);
      repeat (2) @(negedge clk);
      #1;
      checkOutput("rst_req_ready", 32'(bus.req_ready), 32'h0);
      checkOutput("rst_rsp_valid", 32'(bus.rsp_valid), 32'h0);
      checkOutput("rst_rsp_id", 32'(bus.rsp_id), 32'h0);
      checkOutput("rst_rsp_quotient", 32'(bus.rsp_quotient), 32'h0);
      checkOutput("rst_rsp_remainder", 32'(bus.rsp_remainder), 32'h0);
      checkOutput("rst_rsp_err", 32'(bus.rsp_err), 32'h0);
      checkOutput("rst_div_start", 32'(div_start), 32'h0);
      checkOutput("rst_div_dividend", 32'(div_dividend), 32'h0);
      checkOutput("rst_div_divisor", 32'(div_divisor), 32'h0);
      checkOutput("rst_div_abort", 32'(div_abort), 32'h0);

      $display("[TB] single request 100/7");
      rst_n = 1'b1;
      #1;
      checkOutput("t1_grant", 32'(bus.req_ready), 32'h1);
      @(negedge clk);
      bus.req_valid = '0;
      #1;
      checkOutput("t1_div_start", 32'(div_start), 32'h1);
      checkOutput("t1_div_dividend", 32'(div_dividend), 32'd100);
      checkOutput("t1_div_divisor", 32'(div_divisor), 32'd7);
      checkOutput("t1_ready_busy", 32'(bus.req_ready), 32'h0);
      @(negedge clk);
      checkOutput("t1_start_pulse", 32'(div_start), 32'h0);
      lat = 2;
      while (!bus.rsp_valid && lat < 40) begin
         @(negedge clk);
         lat++;
      end
      checkOutput("t1_latency", 32'(lat), 32'd10);
      checkOutput("t1_id", 32'(bus.rsp_id), 32'd0);
      checkOutput("t1_quotient", 32'(bus.rsp_quotient), 32'd14);
      checkOutput("t1_remainder", 32'(bus.rsp_remainder), 32'd2);
      checkOutput("t1_err", 32'(bus.rsp_err), 32'd0);
      bus.rsp_ready = 1'b1;
      @(negedge clk);
      checkOutput("t1_accepted", 32'(bus.rsp_valid), 32'h0);

      $display("[TB] round-robin with all requesters valid");
      rst_n = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      applyStimulus(0, 8'd100, 8'd7);
      applyStimulus(1, 8'd200, 8'd9);
      applyStimulus(2, 8'd55, 8'd5);
      applyStimulus(3, 8'd250, 8'd16);
      #1;
      for (int g = 0; g < 5; g++) begin
         k = 0;
         while (bus.req_ready == '0 && k < 30) begin
            @(negedge clk);
            #1;
            k++;
         end
         checkOutput($sformatf("rr_grant%0d", g), 32'(bus.req_ready), 32'(1 << order[g]));
         if (g > 0) checkOutput($sformatf("rr_spacing%0d", g), 32'(cyc - last_grant), 32'd11);
         last_grant = cyc;
         @(negedge clk);
         k = 0;
         while (!bus.rsp_valid && k < 30) begin
            @(negedge clk);
            k++;
         end
         checkOutput($sformatf("rr_id%0d", g), 32'(bus.rsp_id), 32'(order[g]));
         checkOutput($sformatf("rr_q%0d", g), 32'(bus.rsp_quotient), 32'(q_tab[order[g]]));
         checkOutput($sformatf("rr_r%0d", g), 32'(bus.rsp_remainder), 32'(r_tab[order[g]]));
      end

      $display("[TB] requester 2 alone");
      bus.req_valid = 4'b0100;
      @(negedge clk);
      #1;
      checkOutput("solo_grant", 32'(bus.req_ready), 32'h4);
      checkOutput("solo_spacing", 32'(cyc - last_grant), 32'd11);
      @(negedge clk);
      k = 0;
      while (!bus.rsp_valid && k < 30) begin
         @(negedge clk);
         k++;
      end
      checkOutput("solo_id", 32'(bus.rsp_id), 32'd2);
      checkOutput("solo_q", 32'(bus.rsp_quotient), 32'd11);

      $display("[TB] divide by zero 55/0");
      bus.req_divisor[2*WIDTH +: WIDTH] = '0;
      @(negedge clk);
      #1;
      checkOutput("dbz_grant", 32'(bus.req_ready), 32'h4);
      @(negedge clk);
      checkOutput("dbz_rsp_valid", 32'(bus.rsp_valid), 32'h1);
      checkOutput("dbz_q", 32'(bus.rsp_quotient), 32'hFF);
      checkOutput("dbz_r", 32'(bus.rsp_remainder), 32'd55);
      checkOutput("dbz_err", 32'(bus.rsp_err), 32'h1);
      checkOutput("dbz_id", 32'(bus.rsp_id), 32'd2);
      checkOutput("dbz_div_start", 32'(div_start), 32'h0);
      bus.req_valid = '0;
      @(negedge clk);
      checkOutput("dbz_accepted", 32'(bus.rsp_valid), 32'h0);

      $display("[TB] backpressure on response");
      bus.rsp_ready = 1'b0;
      applyStimulus(1, 8'd200, 8'd9);
      #1;
      checkOutput("bp_grant", 32'(bus.req_ready), 32'h2);
      @(negedge clk);
      bus.req_valid = '0;
      k = 0;
      while (!bus.rsp_valid && k < 30) begin
         @(negedge clk);
         k++;
      end
      applyStimulus(3, 8'd250, 8'd16);
      #1;
      for (int i = 0; i < 5; i++) begin
         checkOutput($sformatf("bp_valid%0d", i), 32'(bus.rsp_valid), 32'h1);
         checkOutput($sformatf("bp_q%0d", i), 32'(bus.rsp_quotient), 32'd22);
         checkOutput($sformatf("bp_r%0d", i), 32'(bus.rsp_remainder), 32'd2);
         checkOutput($sformatf("bp_id%0d", i), 32'(bus.rsp_id), 32'd1);
         checkOutput($sformatf("bp_ready%0d", i), 32'(bus.req_ready), 32'h0);
         @(negedge clk);
         #1;
      end
      bus.rsp_ready = 1'b1;
      checkOutput("bp_valid_final", 32'(bus.rsp_valid), 32'h1);
      @(negedge clk);
      #1;
      checkOutput("bp_next_grant", 32'(bus.req_ready), 32'h8);
      checkOutput("bp_released", 32'(bus.rsp_valid), 32'h0);

      $display("[TB] reset during WAIT");
      @(negedge clk);
      bus.req_valid = '0;
      checkOutput("rw_div_start", 32'(div_start), 32'h1);
      repeat (2) @(negedge clk);
      rst_n = 1'b0;
      @(negedge clk);
      checkOutput("rw_rsp_valid", 32'(bus.rsp_valid), 32'h0);
      checkOutput("rw_rsp_id", 32'(bus.rsp_id), 32'h0);
      checkOutput("rw_rsp_q", 32'(bus.rsp_quotient), 32'h0);
      checkOutput("rw_rsp_r", 32'(bus.rsp_remainder), 32'h0);
      checkOutput("rw_div_dividend", 32'(div_dividend), 32'h0);
      checkOutput("rw_div_divisor", 32'(div_divisor), 32'h0);
      rst_n = 1'b1;
      @(negedge clk);
      stray_done = 1'b1;
      @(negedge clk);
      stray_done = 1'b0;
      saw = 1'b0;
      repeat (8) begin
         if (bus.rsp_valid) saw = 1'b1;
         @(negedge clk);
      end
      checkOutput("rw_stray_ignored", 32'(saw), 32'h0);
      applyStimulus(0, 8'd100, 8'd7);
      applyStimulus(2, 8'd55, 8'd5);
      #1;
      checkOutput("rw_first_grant", 32'(bus.req_ready), 32'h1);
      @(negedge clk);
      bus.req_valid = '0;
      k = 0;
      while (!bus.rsp_valid && k < 30) begin
         @(negedge clk);
         k++;
      end
      checkOutput("rw_id", 32'(bus.rsp_id), 32'd0);
      checkOutput("rw_q", 32'(bus.rsp_quotient), 32'd14);

`ifdef DIV_TIMEOUT_EN
      $display("[TB] watchdog timeout");
      model_en = 1'b0;
      applyStimulus(3, 8'd250, 8'd16);
      @(negedge clk);
      #1;
      checkOutput("to_grant", 32'(bus.req_ready), 32'h8);
      @(negedge clk);
      bus.req_valid = '0;
      checkOutput("to_div_start", 32'(div_start), 32'h1);
      lat = 0;
      while (!div_abort && lat < 60) begin
         @(negedge clk);
         lat++;
      end
      checkOutput("to_latency", 32'(lat), 32'd33);
      checkOutput("to_rsp_valid", 32'(bus.rsp_valid), 32'h1);
      checkOutput("to_q", 32'(bus.rsp_quotient), 32'h0);
      checkOutput("to_r", 32'(bus.rsp_remainder), 32'h0);
      checkOutput("to_err", 32'(bus.rsp_err), 32'h1);
      @(negedge clk);
      checkOutput("to_abort_pulse", 32'(div_abort), 32'h0);
      model_en = 1'b1;
`endif

      @(negedge clk);
      checkOutput("end_div_abort", 32'(div_abort), 32'h0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_checks, n_errs);
      $finish;
   end
endmodule
